// File: rtl/toccata_pkg.sv
// +----------------------------------------------------------------------------
// | toccata_pkg : shared types and AD1848 rate-increment table for the
// |               Toccata playback engine.
// | Revision    : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package toccata_pkg;

  typedef enum logic [1:0] {
    FMT_U8    = 2'd0,
    FMT_S16LE = 2'd1,
    FMT_S8    = 2'd2,
    FMT_RSVD  = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Index is {css, freq_sel}; rates are held in half-hertz so 5512.5 Hz is exact.
  // The two reserved XTAL1 codes map to rate 0, which never ticks.
  function automatic logic [31:0] rate_inc(input logic [63:0] clk_hz, input logic [3:0] sel);
    logic [63:0] r2;
    case (sel)
      4'd0:    r2 = 64'd16000;
      4'd1:    r2 = 64'd32000;
      4'd2:    r2 = 64'd54840;
      4'd3:    r2 = 64'd64000;
      4'd6:    r2 = 64'd96000;
      4'd7:    r2 = 64'd19200;
      4'd8:    r2 = 64'd11025;
      4'd9:    r2 = 64'd22050;
      4'd10:   r2 = 64'd37800;
      4'd11:   r2 = 64'd44100;
      4'd12:   r2 = 64'd75600;
      4'd13:   r2 = 64'd88200;
      4'd14:   r2 = 64'd66150;
      4'd15:   r2 = 64'd13230;
      default: r2 = 64'd0;
    endcase
    return 32'(((r2 << 31) + (clk_hz >> 1)) / clk_hz);
  endfunction

endpackage

`default_nettype wire

// File: rtl/toccata_rate_nco.sv
// +----------------------------------------------------------------------------
// | toccata_rate_nco : 32-bit phase accumulator; tick on each carry-out.
// | Revision         : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module toccata_rate_nco
  import toccata_pkg::*;
#(
  parameter int CLK_FREQUENCY = 28_359_380
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pen,
  input  logic       css,
  input  logic [2:0] freq_sel,
  output logic       tick
);

  logic [31:0] w_tab [16];
  logic [31:0] w_inc;
  logic [31:0] w_sum;
  logic        w_carry;
  logic [31:0] r_acc;

  for (genvar g = 0; g < 16; g++) begin : g_inc
    assign w_tab[g] = rate_inc(64'(CLK_FREQUENCY), 4'(g));
  end

  assign w_inc            = w_tab[{css, freq_sel}];
  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, w_inc};
  assign tick             = pen & w_carry;

  always_ff @(posedge clk) begin
    if (rst || !pen) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_sum;
    end
  end

endmodule

`default_nettype wire

// File: rtl/toccata_playback_ng.sv
// +----------------------------------------------------------------------------
// | toccata_playback_ng : FIFO-to-DAC frame reader with format conversion.
// | Option TOCCATA_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter.
// | Revision            : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module toccata_playback_ng
  import toccata_pkg::*;
#(
  parameter int CLK_FREQUENCY = 28_359_380,
  parameter int NUM_CH        = 2,
  parameter int CNT_W         = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pen,
  input  logic                  css,
  input  logic [2:0]            freq_sel,
  input  logic [1:0]            fmt,
  input  logic [2:0]            ch_cnt,
  input  logic                  mute_on_underrun,
  output logic                  rst_fifo,
  output logic                  rd_en,
  input  logic [7:0]            data_in,
  input  logic [CNT_W-1:0]      fifo_count,
  output logic [16*NUM_CH-1:0]  sdata,
  output logic                  endata,
  output logic                  underrun
`ifdef TOCCATA_UNDERRUN_CNT_EN
  , output logic [15:0]         underrun_cnt
`endif
);

  localparam logic [2:0] c_NUM_CH    = 3'(NUM_CH);
  localparam int         c_BUF_DEPTH = 8;

  state_e              r_state;
  state_e              w_next;
  logic                w_tick;
  logic                w_chg;
  logic                w_live;
  logic                w_enough;
  logic                w_commit;
  logic                w_ur;
  logic [2:0]          w_ch_eff;
  logic [3:0]          w_bpf;
  logic [1:0]          r_fmt_q;
  logic [2:0]          r_ch_q;
  logic                r_rst_q;
  logic [3:0]          r_rd_cnt;
  logic                r_rd_d;
  logic [2:0]          r_widx;
  logic [7:0]          r_buf   [c_BUF_DEPTH];
  logic [7:0]          w_bytes [c_BUF_DEPTH];
  logic [15:0]         w_ch_val [NUM_CH];
  logic [16*NUM_CH-1:0] w_frame;

  toccata_rate_nco #(
    .CLK_FREQUENCY (CLK_FREQUENCY)
  ) u_nco (
    .clk      (clk),
    .rst      (rst),
    .pen      (pen),
    .css      (css),
    .freq_sel (freq_sel),
    .tick     (w_tick)
  );

  always_comb begin
    w_ch_eff = (ch_cnt == 3'd0 || ch_cnt > c_NUM_CH) ? c_NUM_CH : ch_cnt;
    w_bpf    = (fmt == FMT_S16LE) ? {w_ch_eff, 1'b0} : {1'b0, w_ch_eff};
    w_enough = fifo_count >= CNT_W'(w_bpf);
    w_chg    = (fmt != r_fmt_q) || (ch_cnt != r_ch_q);
  end

  // Previous-cycle configuration; loaded during reset too so release is not a "change".
  always_ff @(posedge clk) begin
    r_fmt_q <= fmt;
    r_ch_q  <= ch_cnt;
    r_rst_q <= rst;
  end

  assign rst_fifo = r_rst_q | w_chg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!pen || w_chg) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_tick && w_enough) w_next = ST_READ;
        ST_READ:   if (r_rd_cnt == w_bpf - 4'd1) w_next = ST_COMMIT;
        ST_COMMIT: w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_live   = pen && !w_chg && !rst;
    rd_en    = (r_state == ST_READ) && w_live;
    w_commit = (r_state == ST_COMMIT) && w_live;
    w_ur     = (r_state == ST_IDLE) && w_tick && !w_enough && w_live;
  end

  // The last byte is still on data_in during COMMIT, so it bypasses the buffer.
  always_comb begin
    for (int i = 0; i < c_BUF_DEPTH; i++) begin
      w_bytes[i] = (r_rd_d && r_widx == 3'(i)) ? data_in : r_buf[i];
    end
    for (int k = 0; k < NUM_CH; k++) begin
      case (fmt_e'(fmt))
        FMT_S16LE: w_ch_val[k] = {w_bytes[2*k+1], w_bytes[2*k]};
        FMT_S8:    w_ch_val[k] = {w_bytes[k], 8'h00};
        default:   w_ch_val[k] = {w_bytes[k] ^ 8'h80, 8'h00};
      endcase
    end
    w_frame = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_ch_eff == 3'd1) begin
        w_frame[16*k +: 16] = w_ch_val[0];
      end else if (3'(k) < w_ch_eff) begin
        w_frame[16*k +: 16] = w_ch_val[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_rd_d) begin
      r_buf[r_widx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_rd_d   <= 1'b0;
      r_widx   <= '0;
      sdata    <= '0;
      endata   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      r_rd_d   <= rd_en;
      underrun <= w_ur;
      endata   <= 1'b0;
      r_rd_cnt <= (r_state == ST_READ) ? r_rd_cnt + 4'd1 : 4'd0;
      if (r_state == ST_IDLE) begin
        r_widx <= '0;
      end else if (r_rd_d) begin
        r_widx <= r_widx + 3'd1;
      end
      if (w_commit) begin
        sdata  <= w_frame;
        endata <= 1'b1;
      end else if (w_ur && mute_on_underrun) begin
        sdata  <= '0;
        endata <= 1'b1;
      end
    end
  end

`ifdef TOCCATA_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || rst_fifo) begin
      underrun_cnt <= '0;
    end else if (underrun && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_toccata_playback_ng.sv
// +----------------------------------------------------------------------------
// | tb_toccata_playback_ng : scoreboard bench with a behavioural FIFO model.
// | Revision               : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_toccata_playback_ng;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 12;
  localparam int CLK_HZ = 48000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 pen = 1'b0;
  logic                 css = 1'b1;
  logic [2:0]           freq_sel = 3'd0;
  logic [1:0]           fmt = 2'd0;
  logic [2:0]           ch_cnt = 3'd2;
  logic                 mute_on_underrun = 1'b1;
  logic                 rst_fifo;
  logic                 rd_en;
  logic [7:0]           data_in = 8'h00;
  logic [CNT_W-1:0]     fifo_count = '0;
  logic [16*NUM_CH-1:0] sdata;
  logic                 endata;
  logic                 underrun;
`ifdef TOCCATA_UNDERRUN_CNT_EN
  logic [15:0]          underrun_cnt;
`endif

  always #5 clk = ~clk;

  toccata_playback_ng #(
    .CLK_FREQUENCY (CLK_HZ),
    .NUM_CH        (NUM_CH),
    .CNT_W         (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pen              (pen),
    .css              (css),
    .freq_sel         (freq_sel),
    .fmt              (fmt),
    .ch_cnt           (ch_cnt),
    .mute_on_underrun (mute_on_underrun),
    .rst_fifo         (rst_fifo),
    .rd_en            (rd_en),
    .data_in          (data_in),
    .fifo_count       (fifo_count),
    .sdata            (sdata),
    .endata           (endata),
    .underrun         (underrun)
`ifdef TOCCATA_UNDERRUN_CNT_EN
    , .underrun_cnt   (underrun_cnt)
`endif
  );

  typedef struct {
    logic [63:0] sd;
    int          cyc;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] fifo_q [$];
  logic [7:0] pend_q [$];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int ur_n = 0, en_n = 0, rd_n = 0, rf_n = 0;
  int run = 0, last_run = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO with one-cycle read latency; pushes from stimulus land at the next edge.
  always @(posedge clk) begin
    if (rst_fifo) fifo_q.delete();
    else if (rd_en && fifo_q.size() > 0) data_in <= fifo_q.pop_front();
    while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    fifo_count <= CNT_W'(fifo_q.size());
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (underrun) ur_n++;
      if (rst_fifo) rf_n++;
      if (rd_en) begin
        rd_n++;
        run++;
      end else begin
        if (run > 0) last_run = run;
        run = 0;
      end
      if (endata) begin
        en_n++;
        if (sb_q.size() == 0) begin
          chk("unexpected_endata", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sdata", sdata, e.sd);
          chk("endata_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic set_cfg(input logic [1:0] f, input logic [2:0] c);
    @(posedge clk); #1;
    fmt = f;
    ch_cnt = c;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Tick lands 8 cycles after pen rises (5512.5 Hz at 48 kHz clock); next tick at +17.
  task automatic run_frame(input bit exp_out, input logic [63:0] exp_sd, input int lat);
    exp_t e;
    int   k;
    @(posedge clk); #1;
    pen = 1'b1;
    k = cyc;
    if (exp_out) begin
      e.sd  = exp_sd;
      e.cyc = k + lat;
      sb_q.push_back(e);
    end
    repeat (14) @(posedge clk);
    #1 pen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ur0, en0, rd0, rf0, ticks;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sdata", sdata, 64'd0);
    chk("rst_endata", 64'(endata), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_rst_fifo", 64'(rst_fifo), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    pend_q.push_back(8'h80); pend_q.push_back(8'hFF);
    run_frame(1'b1, {16'h0000, 16'h0000, 16'h7F00, 16'h0000}, 12);
    chk("u8_rd_run", 64'(last_run), 64'd2);

    rf0 = rf_n;
    set_cfg(2'd1, 3'd2);
    chk("fmt_chg_rst_fifo", 64'(rf_n - rf0), 64'd1);
    pend_q.push_back(8'h34); pend_q.push_back(8'h12);
    pend_q.push_back(8'hCD); pend_q.push_back(8'hAB);
    run_frame(1'b1, {16'h0000, 16'h0000, 16'hABCD, 16'h1234}, 14);
    chk("s16_rd_run", 64'(last_run), 64'd4);

    set_cfg(2'd2, 3'd1);
    pend_q.push_back(8'h90);
    run_frame(1'b1, {16'h9000, 16'h9000, 16'h9000, 16'h9000}, 11);
    chk("mono_rd_run", 64'(last_run), 64'd1);

    set_cfg(2'd0, 3'd2);
    mute_on_underrun = 1'b0;
    pend_q.push_back(8'h55);
    ur0 = ur_n; en0 = en_n; rd0 = rd_n;
    run_frame(1'b0, 64'd0, 0);
    chk("ur_hold_pulse", 64'(ur_n - ur0), 64'd1);
    chk("ur_hold_endata", 64'(en_n - en0), 64'd0);
    chk("ur_hold_rd_en", 64'(rd_n - rd0), 64'd0);
    chk("ur_hold_sdata", sdata, {16'h9000, 16'h9000, 16'h9000, 16'h9000});
`ifdef TOCCATA_UNDERRUN_CNT_EN
    chk("ur_cnt_1", 64'(underrun_cnt), 64'd1);
`endif

    mute_on_underrun = 1'b1;
    ur0 = ur_n; rd0 = rd_n;
    run_frame(1'b1, 64'd0, 9);
    chk("ur_mute_pulse", 64'(ur_n - ur0), 64'd1);
    chk("ur_mute_rd_en", 64'(rd_n - rd0), 64'd0);
`ifdef TOCCATA_UNDERRUN_CNT_EN
    chk("ur_cnt_2", 64'(underrun_cnt), 64'd2);
`endif

    set_cfg(2'd3, 3'd2);
    set_cfg(2'd0, 3'd2);
    pend_q.push_back(8'h11); pend_q.push_back(8'h22);
    rf0 = rf_n; en0 = en_n;
    @(posedge clk); #1 pen = 1'b1;
    repeat (10) @(posedge clk);
    #1 fmt = 2'd2;
    @(posedge clk); #1 pen = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_rd_run", 64'(last_run), 64'd1);
    chk("abort_rst_fifo", 64'(rf_n - rf0), 64'd1);
    chk("abort_endata", 64'(en_n - en0), 64'd0);
    chk("abort_sdata", sdata, 64'd0);
    pend_q.push_back(8'hA0); pend_q.push_back(8'h05);
    run_frame(1'b1, {16'h0000, 16'h0000, 16'h0500, 16'hA000}, 12);

    mute_on_underrun = 1'b0;
    freq_sel = 3'd5;
    @(posedge clk); #1 pen = 1'b1;
    ticks = 0;
    repeat (CLK_HZ) begin
      @(negedge clk);
      if (dut.u_nco.tick) ticks++;
    end
    #1 pen = 1'b0;
    n_chk++;
    if (ticks >= 44099 && ticks <= 44101) n_pass++;
    else $display("FAIL rate_44k1: got %0d ticks expected 44100 +/- 1", ticks);

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/toccata_playback_ng.md
TOCCATA_PLAYBACK_NG -- requirements
Module: toccata_playback_ng

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 28_359_380: system clock in Hz.
REQ-002 SHALL have parameter NUM_CH, default 2: output channel count, legal range 1..4.
REQ-003 SHALL have parameter CNT_W, default 12: width of fifo_count.
REQ-004 SHALL have port clk, input, 1: the only clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port pen, input, 1: playback enable.
REQ-007 SHALL have port css, input, 1, and port freq_sel, input, 3: rate select, using the AD1848 rate table.
REQ-008 SHALL have port fmt, input, 2: 0 = 8-bit unsigned, 1 = 16-bit signed little-endian, 2 = 8-bit signed, 3 = reserved (treated as 0).
REQ-009 SHALL have port ch_cnt, input, 3: active channels per frame, 1..NUM_CH; 0 or greater than NUM_CH is clamped to NUM_CH.
REQ-010 SHALL have port mute_on_underrun, input, 1: 1 = zero outputs on underrun, 0 = hold the last values.
REQ-011 SHALL have port rst_fifo, output, 1: one-cycle FIFO flush request.
REQ-012 SHALL have port rd_en, output, 1: FIFO pop strobe.
REQ-013 SHALL have port data_in, input, 8: FIFO read data.
REQ-014 SHALL have port fifo_count, input, CNT_W: bytes currently in the FIFO.
REQ-015 SHALL have port sdata, output, 16*NUM_CH: channel k on bits [16k+15:16k], signed.
REQ-016 SHALL have port endata, output, 1: one-cycle strobe when new sdata is committed.
REQ-017 SHALL have port underrun, output, 1: one-cycle strobe when a tick finds an incomplete frame.

Function
REQ-018 Rate generation SHALL use a 32-bit phase accumulator; increment = round(rate*2^32/CLK_FREQUENCY), selected by {css,freq_sel}; a tick SHALL be the cycle the accumulator carries out.
REQ-019 While pen=0, the accumulator SHALL be held at 0, no ticks SHALL occur, and the FSM SHALL return to IDLE; sdata SHALL hold.
REQ-020 Bytes per frame B SHALL equal ch_cnt for 8-bit formats and 2*ch_cnt for 16-bit format.
REQ-021 FSM states SHALL be IDLE, READ and COMMIT.
REQ-022 IDLE SHALL go to READ on a tick with fifo_count >= B; on a tick with fifo_count < B, underrun SHALL pulse, no pop SHALL occur, and the FSM SHALL stay in IDLE.
REQ-023 On underrun with mute_on_underrun=1, sdata SHALL become 0 on the next cycle and endata SHALL pulse; with mute_on_underrun=0, sdata SHALL hold and endata SHALL stay low.
REQ-024 READ SHALL assert rd_en for exactly B consecutive cycles; data_in SHALL be captured one cycle after each rd_en; the FSM SHALL go to COMMIT after the last capture.
REQ-025 COMMIT SHALL update all sdata channels in one cycle, pulse endata in that cycle, then return to IDLE.
REQ-026 Latency SHALL be: tick at cycle T gives rd_en at T+1..T+B and sdata/endata at T+B+2.
REQ-027 Byte order SHALL be channel 0 first; for 16-bit format the LSB precedes the MSB.
REQ-028 Conversion SHALL be: 8-bit unsigned as {data^8'h80, 8'h00}; 8-bit signed as {data, 8'h00}; 16-bit as {MSB, LSB}.
REQ-029 When ch_cnt=1, channel 0 SHALL be replicated to all NUM_CH outputs; otherwise channels >= ch_cnt SHALL output 0.
REQ-030 A tick arriving while not in IDLE SHALL be dropped, with no underrun pulse.
REQ-031 A change of fmt or ch_cnt (versus the previous cycle) SHALL pulse rst_fifo for 1 cycle and force IDLE; a frame in progress SHALL be discarded, rd_en SHALL deassert that cycle, and sdata SHALL hold.
REQ-032 If a change and a tick coincide, the change SHALL win and the tick SHALL be dropped.

Reset
REQ-033 On rst, the following SHALL hold on the next cycle: sdata=0, endata=0, underrun=0, rd_en=0, rst_fifo=1, FSM=IDLE, accumulator=0.
REQ-034 Reset mid-READ SHALL abandon the frame with no further rd_en.

Configuration
REQ-035 With TOCCATA_UNDERRUN_CNT_EN defined, the block SHALL provide output underrun_cnt, 16 bits, which increments on each underrun pulse, saturates at 16'hFFFF, and clears on rst or rst_fifo.
REQ-036 Without TOCCATA_UNDERRUN_CNT_EN, the underrun_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-037 Package toccata_pkg SHALL hold the fmt enum, the FSM state enum, and the rate-increment constant function/table for both crystal columns.
REQ-038 Sub-module toccata_rate_nco SHALL implement the phase accumulator and tick generation (inputs pen, css, freq_sel; output tick).

Verification
REQ-039 NUM_CH=2, fmt=0, ch_cnt=2, bytes 8'h80,8'hFF -> sdata ch0=16'h0000, ch1=16'h7F00, endata at T+4.
REQ-040 fmt=1, ch_cnt=2, bytes 34,12,CD,AB -> ch0=16'h1234, ch1=16'hABCD; rd_en high for 4 consecutive cycles.
REQ-041 ch_cnt=1, fmt=2, byte 8'h90, NUM_CH=4 -> all four channels = 16'h9000.
REQ-042 fifo_count=1 with B=2 at tick -> underrun pulse, no rd_en; mute=1 gives sdata=0 with endata; mute=0 holds; the macro-on build shows underrun_cnt=1.
REQ-043 fmt change during the second READ cycle -> rst_fifo pulses 1 cycle, rd_en drops, sdata unchanged, next frame decodes correctly.
REQ-044 css=1, freq_sel=5 (44.1 kHz) over 1 s of simulated ticks -> 44100 +/- 1 ticks.
